// File: rtl/stb_gen_ctrl.sv
// Sequencing controller for one strobe generator: reset, ready wait, period qualification, lock, drift watch.
// Build option: define STB_GEN_CTRL_AUTO_RELOCK_EN to re-acquire after drift (up to RETRY_MAX times) instead of failing.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | generator off, waiting for start_i
// RESET_GEN | gen_rst_o held for RST_CYCLES cycles
// WAIT_RDY  | generator running, waiting for gen_rdy_i (bounded)
// SAMPLE    | qualifying consecutive strobe periods against TOL
// LOCKED    | strobe output enabled, period watched for drift
// FAIL      | stopped with fail_code_o, waiting for start_i
module stb_gen_ctrl #(
    parameter int T_CNT_WIDTH    = 32,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int STABLE_CNT     = 4,
    parameter int TOL            = 2,
    parameter int RETRY_MAX      = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   gen_rdy_i,
    input  logic                   gen_err_i,
    input  logic                   gen_stb_i,
    input  logic [T_CNT_WIDTH-1:0] gen_period_i,
    output logic                   gen_rst_o,
    output logic                   gen_run_o,
    output logic                   gen_oe_o,
    output logic                   busy_o,
    output logic                   locked_o,
    output logic                   fail_o,
    output logic [1:0]             fail_code_o,
    output logic [T_CNT_WIDTH-1:0] period_o
);

    localparam int RST_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam int MATCH_W = $clog2(STABLE_CNT + 1);

    localparam logic [RST_W-1:0]       RST_LOAD   = RST_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]        TO_LOAD    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MATCH_W-1:0]     MATCH_LOCK = MATCH_W'(STABLE_CNT);
    localparam logic [T_CNT_WIDTH:0]   TOL_V      = (T_CNT_WIDTH + 1)'(TOL);

    localparam logic [1:0] CODE_TIMEOUT = 2'd1;
    localparam logic [1:0] CODE_GEN_ERR = 2'd2;
    localparam logic [1:0] CODE_DRIFT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET_GEN,
        S_WAIT_RDY,
        S_SAMPLE,
        S_LOCKED,
        S_FAIL
    } state_t;

    typedef struct packed {
        logic rst;
        logic run;
        logic busy;
        logic locked;
        logic fail;
    } flags_t;

    function automatic flags_t flags_for(input state_t s);
        flags_t f;
        f = '0;
        case (s)
            S_RESET_GEN: begin f.rst = 1'b1; f.busy = 1'b1; end
            S_WAIT_RDY:  begin f.run = 1'b1; f.busy = 1'b1; end
            S_SAMPLE:    begin f.run = 1'b1; f.busy = 1'b1; end
            S_LOCKED:    begin f.run = 1'b1; f.locked = 1'b1; end
            S_FAIL:      f.fail = 1'b1;
            default:     f = '0;
        endcase
        return f;
    endfunction

    // Widened subtraction so 0 and all-ones periods compare without wrap.
    function automatic logic [T_CNT_WIDTH:0] abs_delta(input logic [T_CNT_WIDTH-1:0] a,
                                                        input logic [T_CNT_WIDTH-1:0] b);
        logic [T_CNT_WIDTH:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[T_CNT_WIDTH] ? ('0 - d) : d;
    endfunction

    state_t                 state;
    flags_t                 flags_q;
    logic [RST_W-1:0]       rst_cnt;
    logic [TO_W-1:0]        to_cnt;
    logic [MATCH_W-1:0]     match_cnt;
    logic                   have_prev;
    logic [T_CNT_WIDTH-1:0] prev_q;
    logic                   stb_q;
    logic                   edge_q;
    logic [T_CNT_WIDTH-1:0] sample_q;
    logic                   in_tol_prev;
    logic                   in_tol_lock;
    logic [MATCH_W-1:0]     match_inc;
`ifdef STB_GEN_CTRL_AUTO_RELOCK_EN
    localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    logic [RETRY_W-1:0]     retry_cnt;
`endif

    assign gen_rst_o = flags_q.rst;
    assign gen_run_o = flags_q.run;
    assign busy_o    = flags_q.busy;
    assign locked_o  = flags_q.locked;
    assign fail_o    = flags_q.fail;

    assign in_tol_prev = (abs_delta(sample_q, prev_q) <= TOL_V);
    assign in_tol_lock = (abs_delta(sample_q, period_o) <= TOL_V);
    assign match_inc   = match_cnt + MATCH_W'(1);

    // Strobe edge and its period are registered together; the FSM acts one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stb_q    <= 1'b0;
            edge_q   <= 1'b0;
            sample_q <= '0;
        end else begin
            stb_q  <= gen_stb_i;
            edge_q <= gen_stb_i & ~stb_q;
            if (gen_stb_i && !stb_q) begin
                sample_q <= gen_period_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            flags_q     <= '0;
            gen_oe_o    <= 1'b0;
            rst_cnt     <= '0;
            to_cnt      <= '0;
            match_cnt   <= '0;
            have_prev   <= 1'b0;
            prev_q      <= '0;
            period_o    <= '0;
            fail_code_o <= '0;
`ifdef STB_GEN_CTRL_AUTO_RELOCK_EN
            retry_cnt   <= '0;
`endif
        end else begin
            gen_oe_o <= 1'b0;
            if (abort_i) begin
                state       <= S_IDLE;
                flags_q     <= flags_for(S_IDLE);
                rst_cnt     <= '0;
                to_cnt      <= '0;
                match_cnt   <= '0;
                have_prev   <= 1'b0;
                prev_q      <= '0;
                fail_code_o <= '0;
`ifdef STB_GEN_CTRL_AUTO_RELOCK_EN
                retry_cnt   <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE, S_FAIL: begin
                        if (start_i) begin
                            state       <= S_RESET_GEN;
                            flags_q     <= flags_for(S_RESET_GEN);
                            rst_cnt     <= RST_LOAD;
                            fail_code_o <= '0;
`ifdef STB_GEN_CTRL_AUTO_RELOCK_EN
                            retry_cnt   <= '0;
`endif
                        end
                    end

                    S_RESET_GEN: begin
                        if (rst_cnt == '0) begin
                            state   <= S_WAIT_RDY;
                            flags_q <= flags_for(S_WAIT_RDY);
                            to_cnt  <= TO_LOAD;
                        end else begin
                            rst_cnt <= rst_cnt - RST_W'(1);
                        end
                    end

                    S_WAIT_RDY: begin
                        if (gen_err_i) begin
                            state       <= S_FAIL;
                            flags_q     <= flags_for(S_FAIL);
                            fail_code_o <= CODE_GEN_ERR;
                        end else if (gen_rdy_i) begin
                            state     <= S_SAMPLE;
                            flags_q   <= flags_for(S_SAMPLE);
                            to_cnt    <= TO_LOAD;
                            match_cnt <= '0;
                            have_prev <= 1'b0;
                        end else if (to_cnt == '0) begin
                            state       <= S_FAIL;
                            flags_q     <= flags_for(S_FAIL);
                            fail_code_o <= CODE_TIMEOUT;
                        end else begin
                            to_cnt <= to_cnt - TO_W'(1);
                        end
                    end

                    S_SAMPLE: begin
                        if (gen_err_i) begin
                            state       <= S_FAIL;
                            flags_q     <= flags_for(S_FAIL);
                            fail_code_o <= CODE_GEN_ERR;
                        end else if (edge_q) begin
                            to_cnt    <= TO_LOAD;
                            prev_q    <= sample_q;
                            have_prev <= 1'b1;
                            if (!have_prev || !in_tol_prev) begin
                                match_cnt <= '0;
                            end else if (match_inc == MATCH_LOCK) begin
                                match_cnt <= '0;
                                period_o  <= sample_q;
                                state     <= S_LOCKED;
                                flags_q   <= flags_for(S_LOCKED);
                            end else begin
                                match_cnt <= match_inc;
                            end
                        end else if (to_cnt == '0) begin
                            state       <= S_FAIL;
                            flags_q     <= flags_for(S_FAIL);
                            fail_code_o <= CODE_TIMEOUT;
                        end else begin
                            to_cnt <= to_cnt - TO_W'(1);
                        end
                    end

                    S_LOCKED: begin
                        if (gen_err_i) begin
                            state       <= S_FAIL;
                            flags_q     <= flags_for(S_FAIL);
                            fail_code_o <= CODE_GEN_ERR;
                        end else if (edge_q && !in_tol_lock) begin
`ifdef STB_GEN_CTRL_AUTO_RELOCK_EN
                            if (retry_cnt == RETRY_W'(RETRY_MAX)) begin
                                state       <= S_FAIL;
                                flags_q     <= flags_for(S_FAIL);
                                fail_code_o <= CODE_DRIFT;
                            end else begin
                                state     <= S_RESET_GEN;
                                flags_q   <= flags_for(S_RESET_GEN);
                                rst_cnt   <= RST_LOAD;
                                retry_cnt <= retry_cnt + RETRY_W'(1);
                            end
`else
                            state       <= S_FAIL;
                            flags_q     <= flags_for(S_FAIL);
                            fail_code_o <= CODE_DRIFT;
`endif
                        end else begin
                            gen_oe_o <= 1'b1;
                        end
                    end

                    default: begin
                        state   <= S_IDLE;
                        flags_q <= flags_for(S_IDLE);
                    end
                endcase
            end
        end
    end

endmodule
